// File: rtl/tinker_pkg.sv
// tinker_pkg: shared types and constants for the memory port arbiter.
//   arb_state_t   : arbiter sequencing states (IDLE/ISSUE/WAIT/RESP)
//   NUM_ARB_PORTS : number of requesters sharing the RAM port
//   WORD_BYTES    : RAM word size in bytes; addresses must be word aligned
//   port_onehot() : port index -> one-hot per-port strobe vector
// Related build macro: MEM_ARB_RR_EN (consumed by mem_arb_pick / top).
package tinker_pkg;

    localparam int NUM_ARB_PORTS = 2;
    localparam int WORD_BYTES    = 8;
    localparam int ALIGN_BITS    = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    function automatic logic [NUM_ARB_PORTS-1:0] port_onehot(input logic port);
        logic [NUM_ARB_PORTS-1:0] vec;
        vec       = '0;
        vec[port] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select for the two-port RAM arbiter.
// Ports:
//   req_valid : per-port request present
//   last      : port granted most recently (only with MEM_ARB_RR_EN)
//   any_valid : at least one port requesting
//   winner    : index of the port to grant this cycle
// Build macro MEM_ARB_RR_EN: defined -> round robin on ties (port != last
// wins); undefined -> fixed priority, port 0 always wins ties.
module mem_arb_pick
    import tinker_pkg::*;
(
    input  logic [NUM_ARB_PORTS-1:0] req_valid,
`ifdef MEM_ARB_RR_EN
    input  logic                     last,
`endif
    output logic                     any_valid,
    output logic                     winner
);

    always_comb begin
        any_valid = |req_valid;
        winner    = 1'b0;
        if (req_valid[0] && req_valid[1]) begin
`ifdef MEM_ARB_RR_EN
            winner = ~last;
`else
            winner = 1'b0;
`endif
        end else if (!req_valid[0]) begin
            // Only port 1 (or nobody) is asking; the value is ignored when
            // nobody is asking.
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single RAM read/write port between the CPU
// (port 0) and the DMA engine (port 1). One transaction in flight at a time:
// accept in IDLE, drive RAM for one ISSUE cycle, wait RAM_LATENCY cycles,
// then pulse resp_valid to the owner for one RESP cycle. Misaligned
// addresses skip the RAM and respond with an error the next cycle.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready/req_write/req_addr/req_wdata : per-port request side
//   resp_valid/resp_rdata/resp_error                 : response side
//   rw_addr/rw_data_in/rw_write_en/rw_data_out/rw_error : RAM pins
// Build macro MEM_ARB_RR_EN: round-robin ties when defined, fixed priority
// (port 0 first, no last-grant register) when undefined.
module mem_port_arbiter
    import tinker_pkg::*;
#(
    parameter int RAM_LATENCY = 1,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_ARB_PORTS-1:0]              req_valid,
    output logic [NUM_ARB_PORTS-1:0]              req_ready,
    input  logic [NUM_ARB_PORTS-1:0]              req_write,
    input  logic [NUM_ARB_PORTS-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_ARB_PORTS-1:0][DATA_W-1:0]  req_wdata,
    output logic [NUM_ARB_PORTS-1:0]              resp_valid,
    output logic [DATA_W-1:0]                     resp_rdata,
    output logic                                  resp_error,
    output logic [ADDR_W-1:0]                     rw_addr,
    output logic [DATA_W-1:0]                     rw_data_in,
    output logic                                  rw_write_en,
    input  logic [DATA_W-1:0]                     rw_data_out,
    input  logic                                  rw_error
);

    localparam int CNT_W = 4;

    arb_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             owner_reg;
    logic             wr_reg;
    logic             any_valid;
    logic             winner;
    logic             aligned;

`ifdef MEM_ARB_RR_EN
    logic             last_reg;
`endif

    mem_arb_pick u_pick (
        .req_valid (req_valid),
`ifdef MEM_ARB_RR_EN
        .last      (last_reg),
`endif
        .any_valid (any_valid),
        .winner    (winner)
    );

    assign aligned = (req_addr[winner][ALIGN_BITS-1:0] == '0);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and the only combinational output, req_ready. The reset
    // term keeps req_ready low while reset is held even though the state
    // register already reads IDLE.
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        case (state_reg)
            IDLE: begin
                if (any_valid && reset) begin
                    req_ready  = port_onehot(winner);
                    state_next = aligned ? ISSUE : RESP;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg     <= '0;
            owner_reg   <= 1'b0;
            wr_reg      <= 1'b0;
            resp_valid  <= '0;
            resp_rdata  <= '0;
            resp_error  <= 1'b0;
            rw_addr     <= '0;
            rw_data_in  <= '0;
            rw_write_en <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_reg    <= 1'b1;
`endif
        end else begin
            // Responses are single-cycle pulses; error is only meaningful
            // alongside resp_valid.
            resp_valid <= '0;
            resp_error <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_valid) begin
                        owner_reg <= winner;
                        wr_reg    <= req_write[winner];
`ifdef MEM_ARB_RR_EN
                        last_reg  <= winner;
`endif
                        if (aligned) begin
                            // Registered here so the RAM sees them during ISSUE.
                            rw_addr     <= req_addr[winner];
                            rw_data_in  <= req_wdata[winner];
                            rw_write_en <= req_write[winner];
                        end else begin
                            resp_valid <= port_onehot(winner);
                            resp_error <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    rw_write_en <= 1'b0;
                    cnt_reg     <= CNT_W'(RAM_LATENCY - 1);
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        if (!wr_reg) begin
                            resp_rdata <= rw_data_out;
                        end
                        resp_error <= rw_error;
                        resp_valid <= port_onehot(owner_reg);
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. Instance a uses
// RAM_LATENCY=1, instance b uses RAM_LATENCY=3. Contention expectations
// follow the MEM_ARB_RR_EN build macro.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [1:0]       a_req_valid, a_req_ready, a_req_write, a_resp_valid;
    logic [1:0][63:0] a_req_addr, a_req_wdata;
    logic [63:0]      a_resp_rdata, a_rw_addr, a_rw_data_in, a_rw_data_out;
    logic             a_resp_error, a_rw_write_en, a_rw_error;

    logic [1:0]       b_req_valid, b_req_ready, b_req_write, b_resp_valid;
    logic [1:0][63:0] b_req_addr, b_req_wdata;
    logic [63:0]      b_resp_rdata, b_rw_addr, b_rw_data_in, b_rw_data_out;
    logic             b_resp_error, b_rw_write_en, b_rw_error;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.RAM_LATENCY(1), .ADDR_W(64), .DATA_W(64)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (a_req_valid),
        .req_ready   (a_req_ready),
        .req_write   (a_req_write),
        .req_addr    (a_req_addr),
        .req_wdata   (a_req_wdata),
        .resp_valid  (a_resp_valid),
        .resp_rdata  (a_resp_rdata),
        .resp_error  (a_resp_error),
        .rw_addr     (a_rw_addr),
        .rw_data_in  (a_rw_data_in),
        .rw_write_en (a_rw_write_en),
        .rw_data_out (a_rw_data_out),
        .rw_error    (a_rw_error)
    );

    mem_port_arbiter #(.RAM_LATENCY(3), .ADDR_W(64), .DATA_W(64)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (b_req_valid),
        .req_ready   (b_req_ready),
        .req_write   (b_req_write),
        .req_addr    (b_req_addr),
        .req_wdata   (b_req_wdata),
        .resp_valid  (b_resp_valid),
        .resp_rdata  (b_resp_rdata),
        .resp_error  (b_resp_error),
        .rw_addr     (b_rw_addr),
        .rw_data_in  (b_rw_data_in),
        .rw_write_en (b_rw_write_en),
        .rw_data_out (b_rw_data_out),
        .rw_error    (b_rw_error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_grant [4];
`ifdef MEM_ARB_RR_EN
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10;
        exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
`else
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b01;
        exp_grant[2] = 2'b01; exp_grant[3] = 2'b01;
`endif
        reset = 1'b0;
        a_req_valid = 2'b01; a_req_write = '0; a_req_addr = '0; a_req_wdata = '0;
        a_rw_data_out = '0;  a_rw_error = 1'b0;
        b_req_valid = '0;    b_req_write = '0; b_req_addr = '0; b_req_wdata = '0;
        b_rw_data_out = '0;  b_rw_error = 1'b0;

        // Reset state: no ready even with a request pending.
        #2;
        check("rst_req_ready", 64'(a_req_ready), 64'h0);
        check("rst_resp_valid", 64'(a_resp_valid), 64'h0);
        check("rst_rw_addr", a_rw_addr, 64'h0);
        check("rst_rw_write_en", 64'(a_rw_write_en), 64'h0);
        a_req_valid = 2'b00;
        tick(); tick();
        reset = 1'b1;
        tick();

        // Load, port 0, latency 1.
        a_req_addr[0] = 64'h1000; a_req_write = 2'b00;
        a_rw_data_out = 64'hDEAD_BEEF; a_req_valid = 2'b01;
        #1 check("load_ready_c0", 64'(a_req_ready), 64'h1);
        tick(); a_req_valid = 2'b00;
        check("load_rw_addr_c1", a_rw_addr, 64'h1000);
        check("load_we_c1", 64'(a_rw_write_en), 64'h0);
        check("load_resp_c1", 64'(a_resp_valid), 64'h0);
        tick();
        check("load_we_c2", 64'(a_rw_write_en), 64'h0);
        check("load_resp_c2", 64'(a_resp_valid), 64'h0);
        tick();
        check("load_resp_c3", 64'(a_resp_valid), 64'h1);
        check("load_rdata_c3", a_resp_rdata, 64'hDEAD_BEEF);
        check("load_err_c3", 64'(a_resp_error), 64'h0);
        check("load_we_c3", 64'(a_rw_write_en), 64'h0);
        $display("txn load port0 addr=0x1000 rdata=0x%0h", a_resp_rdata);
        tick();
        check("load_resp_c4", 64'(a_resp_valid), 64'h0);

        // Store, port 1.
        a_rw_data_out = 64'h1234;
        a_req_addr[1] = 64'h2008; a_req_wdata[1] = 64'h55;
        a_req_write = 2'b10; a_req_valid = 2'b10;
        #1 check("store_ready_c0", 64'(a_req_ready), 64'h2);
        tick(); a_req_valid = 2'b00;
        check("store_we_c1", 64'(a_rw_write_en), 64'h1);
        check("store_rw_addr_c1", a_rw_addr, 64'h2008);
        check("store_rw_data_c1", a_rw_data_in, 64'h55);
        tick();
        check("store_we_c2", 64'(a_rw_write_en), 64'h0);
        tick();
        check("store_resp_c3", 64'(a_resp_valid), 64'h2);
        check("store_rdata_held", a_resp_rdata, 64'hDEAD_BEEF);
        check("store_err_c3", 64'(a_resp_error), 64'h0);
        $display("txn store port1 addr=0x2008 wdata=0x55");
        tick();

        // Contention: both ports valid for four transactions.
        a_req_write = 2'b00;
        a_req_addr[0] = 64'h100; a_req_addr[1] = 64'h200;
        a_rw_data_out = 64'hAB; a_req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 check("cont_grant", 64'(a_req_ready), 64'(exp_grant[k]));
            tick();
            check("cont_no_ready_c1", 64'(a_req_ready), 64'h0);
            tick(); tick();
            check("cont_resp_c3", 64'(a_resp_valid), 64'(exp_grant[k]));
            $display("txn contention %0d grant=%b", k, a_resp_valid);
            tick();
        end
        a_req_valid = 2'b00;
        tick();

        // Misaligned load, port 0.
        a_req_addr[0] = 64'h1003; a_req_valid = 2'b01;
        #1 check("mis_ready_c0", 64'(a_req_ready), 64'h1);
        tick(); a_req_valid = 2'b00;
        check("mis_resp_c1", 64'(a_resp_valid), 64'h1);
        check("mis_err_c1", 64'(a_resp_error), 64'h1);
        check("mis_we_c1", 64'(a_rw_write_en), 64'h0);
        $display("txn misaligned port0 addr=0x1003 err=%0b", a_resp_error);
        tick();
        check("mis_resp_c2", 64'(a_resp_valid), 64'h0);
        check("mis_we_c2", 64'(a_rw_write_en), 64'h0);
        tick();

        // RAM error, latency 3.
        b_rw_error = 1'b1; b_rw_data_out = 64'h99;
        b_req_addr[0] = 64'h3000; b_req_valid = 2'b01;
        #1 check("ramerr_ready_c0", 64'(b_req_ready), 64'h1);
        tick(); b_req_valid = 2'b00;
        check("ramerr_rw_addr_c1", b_rw_addr, 64'h3000);
        check("ramerr_we_c1", 64'(b_rw_write_en), 64'h0);
        for (int c = 1; c < 5; c++) begin
            check("ramerr_no_resp", 64'(b_resp_valid), 64'h0);
            tick();
        end
        check("ramerr_resp_c5", 64'(b_resp_valid), 64'h1);
        check("ramerr_err_c5", 64'(b_resp_error), 64'h1);
        check("ramerr_rdata_c5", b_resp_rdata, 64'h99);
        $display("txn ram_error port0 addr=0x3000 err=%0b", b_resp_error);
        tick();
        check("ramerr_resp_c6", 64'(b_resp_valid), 64'h0);

        // Reset during WAIT.
        a_req_addr[1] = 64'h40; a_req_wdata[1] = 64'h77;
        a_req_write = 2'b10; a_req_valid = 2'b10;
        #1 check("rstmid_ready_c0", 64'(a_req_ready), 64'h2);
        tick(); a_req_valid = 2'b11; a_req_write = 2'b00;
        check("rstmid_we_c1", 64'(a_rw_write_en), 64'h1);
        tick();
        reset = 1'b0;
        #1;
        check("rstmid_req_ready", 64'(a_req_ready), 64'h0);
        check("rstmid_resp_valid", 64'(a_resp_valid), 64'h0);
        check("rstmid_resp_error", 64'(a_resp_error), 64'h0);
        check("rstmid_resp_rdata", a_resp_rdata, 64'h0);
        check("rstmid_rw_addr", a_rw_addr, 64'h0);
        check("rstmid_rw_data_in", a_rw_data_in, 64'h0);
        check("rstmid_rw_write_en", 64'(a_rw_write_en), 64'h0);
        tick(); tick();
        a_req_valid = 2'b00;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rstmid_no_resp", 64'(a_resp_valid), 64'h0);
        end
        a_req_valid = 2'b11;
        #1 check("rstmid_tie_port0", 64'(a_req_ready), 64'h1);
        $display("txn reset_mid_op tie grant=%b", a_req_ready);
        tick(); a_req_valid = 2'b00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
